// File: rtl/expr_eval_pipe.sv
// expr_eval_pipe: two-stage valid/ready pipeline evaluating three bitwise
// boolean expressions of four operand vectors plus a mode-selected result.
// Stage 1 captures shared sub-terms, stage 2 combines them into the results.
module expr_eval_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s1,
  output logic [WIDTH-1:0] s2,
  output logic [WIDTH-1:0] s3,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] count
);

  // stage valid bits
  logic v1, v2;

  // stage-1 sub-terms shared by the three result expressions
  logic [WIDTH-1:0] ab_or, cd_or, na_or_b, a_and_nb, c_and_ad;
  logic [1:0]       mode_q;

  // next-stage values computed from stage-1 registers
  logic [WIDTH-1:0] s1_n, s2_n, s3_n, y_n;

  logic load1, load2, in_xfer, out_xfer;

  // handshake and advance conditions; stage 1 may refill in the same cycle
  // stage 2 drains, so a full pipe streams without bubbles
  always_comb begin
    load2    = v1 & (~v2 | out_ready);
    load1    = ~v1 | load2;
    in_ready = ~v1 | ~v2 | out_ready;
    in_xfer  = in_valid & in_ready;
    out_xfer = v2 & out_ready;
  end

  assign out_valid = v2;

  // combine stage-1 sub-terms into the results and select y by the captured mode
  always_comb begin
    s1_n = na_or_b;
    s2_n = ab_or & cd_or;
    s3_n = a_and_nb | ~c_and_ad;
    y_n  = s1_n;
    case (mode_q)
      2'b00:   y_n = s1_n;
      2'b01:   y_n = s2_n;
      2'b10:   y_n = s3_n;
      default: y_n = s1_n ^ s2_n ^ s3_n;
    endcase
  end

  // stage 1: capture sub-terms and mode together so later mode changes cannot
  // affect data already in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      ab_or    <= '0;
      cd_or    <= '0;
      na_or_b  <= '0;
      a_and_nb <= '0;
      c_and_ad <= '0;
      mode_q   <= '0;
    end else if (load1) begin
      v1 <= in_valid;
      if (in_valid) begin
        ab_or    <= a | b;
        cd_or    <= c | d;
        na_or_b  <= ~a | b;
        a_and_nb <= a & ~b;
        c_and_ad <= c & (a | d);
        mode_q   <= mode;
      end
    end
  end

  // stage 2: results only change on a load, so they stay stable under
  // backpressure and keep their last values once drained
  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      y  <= '0;
    end else if (load2) begin
      v2 <= 1'b1;
      s1 <= s1_n;
      s2 <= s2_n;
      s3 <= s3_n;
      y  <= y_n;
    end else if (out_ready) begin
      v2 <= 1'b0;
    end
  end

  // delivered-result counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst)           count <= '0;
    else if (out_xfer) count <= count + CNT_W'(1);
  end

endmodule

// File: tb/tb_expr_eval_pipe.sv
// Bench for expr_eval_pipe: a WIDTH=4/CNT_W=4 instance for handshake, ordering,
// backpressure, counter wrap and reset scenarios, and a WIDTH=1 instance for an
// exhaustive truth-table sweep. Expected results are queued when operands are
// accepted and compared when the DUT delivers a result.
module tb_expr_eval_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-bit instance signals
  logic       iv = 1'b0, ordy = 1'b0, ir, ov;
  logic [3:0] a4 = '0, b4 = '0, c4 = '0, d4 = '0;
  logic [1:0] m4 = '0;
  logic [3:0] s1o, s2o, s3o, yo, cnt4;

  // 1-bit instance signals
  logic       iv1 = 1'b0, ordy1 = 1'b0, ir1, ov1;
  logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0, d1 = 1'b0;
  logic [1:0] m1 = '0;
  logic       s1b, s2b, s3b, yb;
  logic [15:0] cnt1;

  int pass_cnt = 0;
  int total    = 0;

  logic [15:0] q4[$];
  logic [3:0]  q1[$];

  expr_eval_pipe #(.WIDTH(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir),
    .a(a4), .b(b4), .c(c4), .d(d4), .mode(m4),
    .out_valid(ov), .out_ready(ordy),
    .s1(s1o), .s2(s2o), .s3(s3o), .y(yo), .count(cnt4)
  );

  expr_eval_pipe #(.WIDTH(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .c(c1), .d(d1), .mode(m1),
    .out_valid(ov1), .out_ready(ordy1),
    .s1(s1b), .s2(s2b), .s3(s3b), .y(yb), .count(cnt1)
  );

  // reference model, packed as {s1,s2,s3,y}
  function automatic logic [15:0] model(input logic [3:0] a, b, c, d, input logic [1:0] m);
    logic [3:0] t1, t2, t3, ty;
    t1 = ~a | b;
    t2 = (a | b) & (c | d);
    t3 = (a & ~b) | ~(c & (a | d));
    case (m)
      2'b00:   ty = t1;
      2'b01:   ty = t2;
      2'b10:   ty = t3;
      default: ty = t1 ^ t2 ^ t3;
    endcase
    return {t1, t2, t3, ty};
  endfunction

  // scoreboard for the 4-bit instance
  always @(negedge clk) begin
    if (rst) begin
      q4.delete();
    end else begin
      if (ov && ordy) begin
        total++;
        if (q4.size() == 0) begin
          $display("FAIL sb4_unexpected: got %h, required no output", {s1o, s2o, s3o, yo});
        end else begin
          logic [15:0] e;
          e = q4.pop_front();
          if ({s1o, s2o, s3o, yo} !== e)
            $display("FAIL sb4_result: got %h, required %h", {s1o, s2o, s3o, yo}, e);
          else pass_cnt++;
        end
      end
      if (iv && ir) q4.push_back(model(a4, b4, c4, d4, m4));
    end
  end

  // scoreboard for the 1-bit instance
  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
    end else begin
      if (ov1 && ordy1) begin
        total++;
        if (q1.size() == 0) begin
          $display("FAIL sb1_unexpected: got %b, required no output", {s1b, s2b, s3b, yb});
        end else begin
          logic [3:0] e;
          e = q1.pop_front();
          if ({s1b, s2b, s3b, yb} !== e)
            $display("FAIL sb1_result: got %b, required %b (a%b b%b c%b d%b)",
                     {s1b, s2b, s3b, yb}, e, a1, b1, c1, d1);
          else pass_cnt++;
        end
      end
      if (iv1 && ir1) begin
        logic [15:0] r;
        r = model({3'b0, a1}, {3'b0, b1}, {3'b0, c1}, {3'b0, d1}, m1);
        q1.push_back({r[12], r[8], r[4], r[0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1; iv = 1'b0; iv1 = 1'b0;
    tick(); rst = 1'b0;
  endtask

  task automatic drive4(input logic v);
    iv = v;
    a4 = 4'($urandom); b4 = 4'($urandom); c4 = 4'($urandom); d4 = 4'($urandom);
    m4 = 2'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    total++; if (ov !== 1'b0) $display("FAIL rst_out_valid: got %b, required 0", ov); else pass_cnt++;
    total++; if ({s1o, s2o, s3o, yo} !== 16'h0) $display("FAIL rst_outputs: got %h, required 0000", {s1o, s2o, s3o, yo}); else pass_cnt++;
    total++; if (cnt4 !== 4'd0) $display("FAIL rst_count: got %0d, required 0", cnt4); else pass_cnt++;
    total++; if (ir !== 1'b1) $display("FAIL rst_in_ready_during: got %b, required 1", ir); else pass_cnt++;
    tick(); rst = 1'b0;
    @(negedge clk);
    total++; if (ir !== 1'b1) $display("FAIL rst_in_ready_after: got %b, required 1", ir); else pass_cnt++;
  endtask

  // known vector; result visible two cycles after presentation
  task automatic test_vector();
    tick();
    ordy = 1'b1; iv = 1'b1; m4 = 2'b11;
    a4 = 4'b1100; b4 = 4'b1010; c4 = 4'b0110; d4 = 4'b0001;
    tick(); iv = 1'b0; m4 = 2'b00;
    @(negedge clk);
    total++; if (ov !== 1'b0) $display("FAIL vec_early_valid: got %b, required 0", ov); else pass_cnt++;
    tick();
    @(negedge clk);
    total++; if (ov !== 1'b1) $display("FAIL vec_out_valid: got %b, required 1", ov); else pass_cnt++;
    total++;
    if ({s1o, s2o, s3o, yo} !== {4'b1011, 4'b0110, 4'b1111, 4'b0010})
      $display("FAIL vec_values: got %b %b %b %b, required 1011 0110 1111 0010", s1o, s2o, s3o, yo);
    else pass_cnt++;
    tick();
    @(negedge clk);
    total++; if (cnt4 !== 4'd1) $display("FAIL vec_count: got %0d, required 1", cnt4); else pass_cnt++;
    total++; if (ov !== 1'b0) $display("FAIL vec_single: got %b, required 0", ov); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int ov_n = 0, ov_first = -1, ov_last = -1, ir_drops = 0;
    do_reset();
    ordy = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      drive4(i < 10);
      @(negedge clk);
      if (i < 10 && ir !== 1'b1) ir_drops++;
      if (ov === 1'b1) begin
        ov_n++;
        if (ov_first < 0) ov_first = i;
        ov_last = i;
      end
    end
    total++; if (ir_drops != 0) $display("FAIL b2b_in_ready: got %0d drops, required 0", ir_drops); else pass_cnt++;
    total++;
    if (ov_n != 10 || ov_first != 2 || ov_last != 11)
      $display("FAIL b2b_valid_run: got n=%0d first=%0d last=%0d, required n=10 first=2 last=11", ov_n, ov_first, ov_last);
    else pass_cnt++;
    total++; if (cnt4 !== 4'd10) $display("FAIL b2b_count: got %0d, required 10", cnt4); else pass_cnt++;
    total++; if (q4.size() != 0) $display("FAIL b2b_drain: got %0d pending, required 0", q4.size()); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int acc = 0, thaw = 0;
    logic [15:0] held;
    do_reset();
    ordy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 3) drive4(1'b1);
      @(negedge clk);
      if (iv && ir) acc++;
      if (i == 2) held = {s1o, s2o, s3o, yo};
      if (i >= 2) begin
        total++; if (ir !== 1'b0) $display("FAIL bp_in_ready_c%0d: got %b, required 0", i, ir); else pass_cnt++;
        if (i > 2 && {s1o, s2o, s3o, yo} !== held) thaw++;
      end
    end
    total++; if (acc != 2) $display("FAIL bp_accepted: got %0d, required 2", acc); else pass_cnt++;
    total++; if (thaw != 0) $display("FAIL bp_frozen: got %0d changes, required 0", thaw); else pass_cnt++;
    tick(); ordy = 1'b1;
    @(negedge clk);
    total++; if (ir !== 1'b1) $display("FAIL bp_release_ready: got %b, required 1", ir); else pass_cnt++;
    tick(); iv = 1'b0;
    for (int i = 0; i < 10 && q4.size() != 0; i++) tick();
    @(negedge clk);
    total++; if (q4.size() != 0) $display("FAIL bp_drain: got %0d pending, required 0", q4.size()); else pass_cnt++;
    total++; if (cnt4 !== 4'd3) $display("FAIL bp_count: got %0d, required 3", cnt4); else pass_cnt++;
  endtask

  task automatic test_counter_wrap();
    int k = 0;
    do_reset();
    ordy = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      drive4(i < 17);
      @(negedge clk);
      if (k == 15) begin
        total++; if (cnt4 !== 4'd15) $display("FAIL wrap_15: got %0d, required 15", cnt4); else pass_cnt++;
      end
      if (k == 16) begin
        total++; if (cnt4 !== 4'd0) $display("FAIL wrap_16: got %0d, required 0", cnt4); else pass_cnt++;
      end
      if (k == 17) begin
        total++; if (cnt4 !== 4'd1) $display("FAIL wrap_17: got %0d, required 1", cnt4); else pass_cnt++;
      end
      if (ov && ordy) k++;
    end
    total++; if (k != 17) $display("FAIL wrap_deliveries: got %0d, required 17", k); else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    ordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      drive4(i < 2);
    end
    @(negedge clk);
    total++; if (ov !== 1'b1 || ir !== 1'b0) $display("FAIL mid_full: got ov=%b ir=%b, required ov=1 ir=0", ov, ir); else pass_cnt++;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; ordy = 1'b1;
    @(negedge clk);
    total++; if (ov !== 1'b0) $display("FAIL mid_out_valid: got %b, required 0", ov); else pass_cnt++;
    total++; if (cnt4 !== 4'd0) $display("FAIL mid_count: got %0d, required 0", cnt4); else pass_cnt++;
    total++; if ({s1o, s2o, s3o, yo} !== 16'h0) $display("FAIL mid_outputs: got %h, required 0000", {s1o, s2o, s3o, yo}); else pass_cnt++;
    total++; if (ir !== 1'b1) $display("FAIL mid_in_ready: got %b, required 1", ir); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      if (ov !== 1'b0) stale++;
    end
    total++; if (stale != 0) $display("FAIL mid_stale: got %0d stale cycles, required 0", stale); else pass_cnt++;
  endtask

  task automatic test_exhaustive();
    ordy1 = 1'b1;
    for (int i = 0; i < 68; i++) begin
      logic [5:0] v;
      v = 6'(i);
      tick();
      iv1 = (i < 64);
      {a1, b1, c1, d1} = v[3:0];
      m1 = v[5:4];
    end
    for (int i = 0; i < 10 && q1.size() != 0; i++) tick();
    @(negedge clk);
    total++; if (q1.size() != 0) $display("FAIL exh_drain: got %0d pending, required 0", q1.size()); else pass_cnt++;
    total++; if (cnt1 !== 16'd64) $display("FAIL exh_count: got %0d, required 64", cnt1); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_vector();
    test_back_to_back();
    test_backpressure();
    test_counter_wrap();
    test_reset_midflight();
    test_exhaustive();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
